// File: rtl/calc_pkg.sv
// Shared encodings for the calculator sequencer: keypad codes, ALU ops,
// result-holder select values and the sequencer state enum.
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_EQ  = 4'd14;
  localparam logic [3:0] KEY_CLR = 4'd15;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam logic [2:0] SEL_IDLE = 3'b000;
  localparam logic [2:0] SEL_SHOW = 3'b011;
  localparam logic [2:0] SEL_CLR  = 3'b100;

  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_ENTER_B = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_SHOW    = 3'd4,
    ST_ERR     = 3'd5
  } state_e;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

  function automatic logic is_oper(input logic [3:0] k);
    return (k >= KEY_ADD) && (k <= KEY_DIV);
  endfunction

  // Operator keys are contiguous and in the same order as the ALU op codes.
  function automatic logic [1:0] key_to_op(input logic [3:0] k);
    logic [3:0] diff;
    diff = k - KEY_ADD;
    return diff[1:0];
  endfunction

endpackage

// File: rtl/calc_sequencer_dec_entry.sv
// Decimal operand accumulator: acc*10+digit, refusing any digit that would
// overflow WIDTH bits. Shared by operands A and B; the sequencer picks which.
module dec_entry #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             digit_i,
  input  logic [3:0]       digit_val_i,
  output logic [WIDTH-1:0] acc_o,
  output logic             digit_ok_o
);

  localparam int XW = WIDTH + 4;
  localparam logic [XW-1:0] TEN     = XW'(10);
  localparam logic [XW-1:0] ACC_MAX = {4'b0000, {WIDTH{1'b1}}};

  logic [XW-1:0] acc_ext;
  logic          fits;

  assign acc_ext    = ({4'b0000, acc_i} * TEN) + {{WIDTH{1'b0}}, digit_val_i};
  assign fits       = (acc_ext <= ACC_MAX);
  assign digit_ok_o = digit_i & fits;

  always_comb begin
    acc_o = acc_i;
    if (clear_i) begin
      acc_o = '0;
    end else if (load_i) begin
      acc_o = load_val_i;
    end else if (digit_ok_o) begin
      acc_o = acc_ext[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM: builds decimal operands from keypad strobes, runs
// the ALU start/done handshake and drives the result holder.
//
// state    | meaning
// ENTER_A  | entering first operand
// ENTER_B  | entering second operand (operator chosen)
// START    | one-cycle alu_start pulse
// WAIT     | waiting for alu_done, bounded by ALU_TIMEOUT
// SHOW     | result presented to holder; keys locked for the first 2 cycles
// ERR      | ALU error or timeout; only CLR exits
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int ALU_TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic             key_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_err,
  output logic [WIDTH-1:0] disp_value,
  output logic [WIDTH-1:0] hold_value,
  output logic [2:0]       holder_sel,
  output logic             error,
  output logic             busy
);

  localparam int              CNT_W     = $clog2(ALU_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ALU_TIMEOUT - 1);
  localparam logic [1:0]       SHOW_OPEN = 2'd2;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hold_q, hold_d;
  logic             a_has_q, a_has_d, b_has_q, b_has_d;
  logic [1:0]       op_q, op_d;
  logic             clr_q, clr_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [1:0]       scnt_q, scnt_d;

  logic             key_acc;
  logic [WIDTH-1:0] de_acc, de_acc_nx;
  logic             de_clear, de_load, de_digit, de_ok;

  always_comb begin
    unique case (state_q)
      ST_ENTER_A, ST_ENTER_B, ST_ERR: key_ready = 1'b1;
      ST_SHOW:                        key_ready = (scnt_q == SHOW_OPEN);
      default:                        key_ready = 1'b0;
    endcase
  end

  assign key_acc = key_valid & key_ready;

  // SHOW feeds a zero accumulator so a digit there starts a fresh A.
  always_comb begin
    unique case (state_q)
      ST_ENTER_B: de_acc = b_q;
      ST_SHOW:    de_acc = '0;
      default:    de_acc = a_q;
    endcase
  end

  assign de_clear = key_acc & (key_code == KEY_CLR);
  assign de_load  = key_acc & is_oper(key_code) & (state_q == ST_SHOW);
  assign de_digit = key_acc & is_digit(key_code) &
                    ((state_q == ST_ENTER_A) || (state_q == ST_ENTER_B) || (state_q == ST_SHOW));

  dec_entry #(.WIDTH(WIDTH)) u_entry (
    .acc_i       (de_acc),
    .clear_i     (de_clear),
    .load_i      (de_load),
    .load_val_i  (hold_q),
    .digit_i     (de_digit),
    .digit_val_i (key_code),
    .acc_o       (de_acc_nx),
    .digit_ok_o  (de_ok)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    a_has_d = a_has_q;
    b_has_d = b_has_q;
    op_d    = op_q;
    hold_d  = hold_q;
    clr_d   = 1'b0;
    wcnt_d  = '0;
    scnt_d  = '0;

    unique case (state_q)
      ST_ENTER_A: begin
        if (key_acc && is_digit(key_code)) begin
          a_d = de_acc_nx;
          if (de_ok) a_has_d = 1'b1;
        end else if (key_acc && is_oper(key_code)) begin
          op_d    = key_to_op(key_code);
          b_d     = '0;
          b_has_d = 1'b0;
          state_d = ST_ENTER_B;
        end
      end
      ST_ENTER_B: begin
        if (key_acc && is_digit(key_code)) begin
          b_d = de_acc_nx;
          if (de_ok) b_has_d = 1'b1;
        end else if (key_acc && is_oper(key_code)) begin
          if (!b_has_q) op_d = key_to_op(key_code);
        end else if (key_acc && (key_code == KEY_EQ) && b_has_q) begin
          state_d = ST_START;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (alu_done) begin
          if (alu_err) begin
            state_d = ST_ERR;
          end else begin
            hold_d  = alu_result;
            state_d = ST_SHOW;
          end
        end else if (wcnt_q == WAIT_LAST) begin
          state_d = ST_ERR;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      ST_SHOW: begin
        scnt_d = (scnt_q == SHOW_OPEN) ? scnt_q : scnt_q + 2'd1;
        if (key_acc && is_digit(key_code)) begin
          a_d     = de_acc_nx;
          a_has_d = 1'b1;
          state_d = ST_ENTER_A;
        end else if (key_acc && is_oper(key_code)) begin
          a_d     = de_acc_nx;
          a_has_d = 1'b1;
          op_d    = key_to_op(key_code);
          b_d     = '0;
          b_has_d = 1'b0;
          state_d = ST_ENTER_B;
        end
      end
      default: ;
    endcase

    if (de_clear) begin
      a_d     = '0;
      b_d     = '0;
      a_has_d = 1'b0;
      b_has_d = 1'b0;
      op_d    = OP_ADD;
      hold_d  = '0;
      clr_d   = 1'b1;
      state_d = ST_ENTER_A;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      a_has_q <= 1'b0;
      b_has_q <= 1'b0;
      op_q    <= OP_ADD;
      hold_q  <= '0;
      clr_q   <= 1'b0;
      wcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      a_has_q <= a_has_d;
      b_has_q <= b_has_d;
      op_q    <= op_d;
      hold_q  <= hold_d;
      clr_q   <= clr_d;
      wcnt_q  <= wcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign alu_start  = (state_q == ST_START);
  assign busy       = (state_q == ST_START) || (state_q == ST_WAIT);
  assign error      = (state_q == ST_ERR);
  assign hold_value = hold_q;

  always_comb begin
    unique case (state_q)
      ST_ENTER_A:     disp_value = a_q;
      ST_SHOW, ST_ERR: disp_value = hold_q;
      default:        disp_value = b_q;
    endcase
  end

  always_comb begin
    if (state_q == ST_SHOW)                 holder_sel = SEL_SHOW;
    else if ((state_q == ST_ERR) || clr_q)  holder_sel = SEL_CLR;
    else                                    holder_sel = SEL_IDLE;
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: a scoreboard checks every alu_start and
// every holder SHOW/CLEAR event; inline checks cover entry and state details.
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int WIDTH = 8;
  localparam int ALU_TIMEOUT = 15;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             key_valid = 1'b0;
  logic [3:0]       key_code = 4'd0;
  logic             key_ready;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result = '0;
  logic [1:0]       alu_op;
  logic             alu_start, alu_done = 1'b0, alu_err = 1'b0;
  logic [WIDTH-1:0] disp_value, hold_value;
  logic [2:0]       holder_sel;
  logic             error, busy;

  calc_sequencer #(.WIDTH(WIDTH), .ALU_TIMEOUT(ALU_TIMEOUT)) dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
    .alu_err(alu_err), .disp_value(disp_value), .hold_value(hold_value),
    .holder_sel(holder_sel), .error(error), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct { logic [7:0] a; logic [7:0] b; logic [1:0] op; } start_t;
  typedef struct { logic [2:0] sel; logic [7:0] hold; logic err; } hevt_t;

  start_t q_start[$];
  hevt_t  q_hevt[$];
  int     n_checks = 0;
  int     n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  logic [2:0] prev_sel = 3'b000;
  start_t     s_cur;
  hevt_t      h_cur;
  always @(negedge clock) begin
    if (!reset && alu_start) begin
      if (q_start.size() == 0) chk("start_unexpected", 1, 0);
      else begin
        s_cur = q_start.pop_front();
        chk("sb_alu_a", alu_a, s_cur.a);
        chk("sb_alu_b", alu_b, s_cur.b);
        chk("sb_alu_op", alu_op, s_cur.op);
      end
    end
    if (!reset && holder_sel != 3'b000 && holder_sel != prev_sel) begin
      if (q_hevt.size() == 0) chk("holder_unexpected", 1, 0);
      else begin
        h_cur = q_hevt.pop_front();
        chk("sb_holder_sel", holder_sel, h_cur.sel);
        chk("sb_hold_value", hold_value, h_cur.hold);
        chk("sb_error", error, h_cur.err);
      end
    end
    prev_sel = holder_sel;
  end

  task automatic press(input logic [3:0] k);
    @(negedge clock);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clock);
    key_valid = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!alu_start && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk("start_seen", alu_start, 1);
  endtask

  task automatic alu_reply(input int dly, input logic [7:0] res, input logic err);
    wait_start();
    repeat (dly) @(negedge clock);
    alu_done   = 1'b1;
    alu_result = res;
    alu_err    = err;
    @(negedge clock);
    alu_done = 1'b0;
    alu_err  = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!key_ready && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk("ready_wait", key_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wcyc;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_key_ready", key_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk("rst_holder_sel", holder_sel, SEL_IDLE);
    chk("rst_hold", hold_value, 0);
    chk("rst_disp", disp_value, 0);
    chk("rst_alu_start", alu_start, 0);

    // 12 + 3 = 15
    q_start.push_back('{8'd12, 8'd3, OP_ADD});
    q_hevt.push_back('{SEL_SHOW, 8'd15, 1'b0});
    press(4'd1); press(4'd2);
    chk("disp_12", disp_value, 12);
    press(KEY_ADD); press(4'd3); press(KEY_EQ);
    alu_reply(3, 8'd15, 1'b0);
    chk("show1_sel", holder_sel, SEL_SHOW);
    chk("show1_locked", key_ready, 0);
    @(negedge clock);
    chk("show2_sel", holder_sel, SEL_SHOW);
    chk("show2_hold", hold_value, 15);
    chk("show2_locked", key_ready, 0);

    // chaining from SHOW: 15 * 2
    wait_ready();
    q_start.push_back('{8'd15, 8'd2, OP_MUL});
    q_hevt.push_back('{SEL_SHOW, 8'd30, 1'b0});
    press(KEY_MUL);
    chk("chain_a", alu_a, 15);
    press(4'd2); press(KEY_EQ);
    alu_reply(1, 8'd30, 1'b0);
    wait_ready();
    press(4'd7);
    chk("show_digit_disp", disp_value, 7);
    chk("show_digit_sel", holder_sel, SEL_IDLE);

    // overflow refusal
    q_hevt.push_back('{SEL_CLR, 8'd0, 1'b0});
    press(KEY_CLR);
    press(4'd2); press(4'd5); press(4'd6);
    chk("ovf_256", disp_value, 25);
    press(4'd9); press(4'd9); press(4'd9);
    chk("ovf_999", disp_value, 25);
    press(KEY_ADD); press(4'd2); press(4'd5); press(4'd5);
    chk("b_255", disp_value, 255);
    press(KEY_SUB);
    chk("op_locked", alu_op, OP_ADD);

    // divide by zero, op replacement, EQ without B digit
    q_hevt.push_back('{SEL_CLR, 8'd0, 1'b0});
    press(KEY_CLR);
    press(4'd8); press(KEY_ADD); press(KEY_DIV);
    chk("op_replace", alu_op, OP_DIV);
    press(KEY_EQ);
    chk("eq_no_b", busy, 0);
    q_start.push_back('{8'd8, 8'd0, OP_DIV});
    q_hevt.push_back('{SEL_CLR, 8'd0, 1'b1});
    press(4'd0); press(KEY_EQ);
    alu_reply(2, 8'd0, 1'b1);
    chk("err_flag", error, 1);
    chk("err_sel", holder_sel, SEL_CLR);
    press(4'd5); press(KEY_EQ);
    chk("err_sticky", error, 1);
    chk("err_disp", disp_value, 0);
    press(KEY_CLR);
    chk("clr_error", error, 0);
    chk("clr_pulse", holder_sel, SEL_CLR);
    chk("clr_ready", key_ready, 1);
    @(negedge clock);
    chk("clr_pulse_end", holder_sel, SEL_IDLE);

    // ALU timeout; a CLR during WAIT must be dropped
    q_start.push_back('{8'd4, 8'd1, OP_SUB});
    q_hevt.push_back('{SEL_CLR, 8'd0, 1'b1});
    press(4'd4); press(KEY_SUB); press(4'd1); press(KEY_EQ);
    wait_start();
    wcyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (error) break;
      if (busy && !alu_start) wcyc++;
      key_valid = (wcyc == 3);
      key_code  = KEY_CLR;
    end
    key_valid = 1'b0;
    chk("timeout_cycles", wcyc, ALU_TIMEOUT);
    chk("timeout_err", error, 1);
    press(KEY_CLR);

    // done coincides with timeout: done wins
    q_start.push_back('{8'd9, 8'd4, OP_SUB});
    q_hevt.push_back('{SEL_SHOW, 8'd5, 1'b0});
    press(4'd9); press(KEY_SUB); press(4'd4); press(KEY_EQ);
    alu_reply(ALU_TIMEOUT, 8'd5, 1'b0);
    chk("done_wins_err", error, 0);
    chk("done_wins_sel", holder_sel, SEL_SHOW);

    // reset during WAIT, late done afterwards
    wait_ready();
    q_start.push_back('{8'd6, 8'd3, OP_MUL});
    press(4'd6); press(KEY_MUL); press(4'd3); press(KEY_EQ);
    wait_start();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset      = 1'b0;
    alu_done   = 1'b1;
    alu_result = 8'd99;
    @(negedge clock);
    alu_done = 1'b0;
    chk("rstw_busy", busy, 0);
    chk("rstw_ready", key_ready, 1);
    chk("rstw_error", error, 0);
    chk("rstw_sel", holder_sel, SEL_IDLE);
    chk("rstw_hold", hold_value, 0);
    chk("rstw_disp", disp_value, 0);
    chk("rstw_alu_a", alu_a, 0);
    chk("rstw_alu_op", alu_op, 0);

    repeat (2) @(negedge clock);
    chk("sb_start_left", q_start.size(), 0);
    chk("sb_holder_left", q_hevt.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
